// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: shared state type and register field positions for the MMIO UART transmitter
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} UartTxState_t;

    localparam int UART_STATUS_ACK       = 0;
    localparam int UART_STATUS_FULL      = 1;
    localparam int UART_STATUS_EMPTY     = 2;
    localparam int UART_STATUS_BUSY      = 3;
    localparam int UART_STATUS_COUNT_LSB = 4;

    localparam int UART_CMD_TOGGLE = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous byte FIFO feeding the UART serialiser
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    logic [7:0]            mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_q;
    logic [DEPTH_LOG2-1:0] rd_q;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  do_push;
    logic                  do_pop;

    // Count never exceeds 2^N, so its top bit alone marks a full FIFO
    assign full    = cnt_q[DEPTH_LOG2];
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^N
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    // Storage array needs no reset; only slots below the write pointer are ever read
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: toggle-handshake MMIO front end, byte FIFO and 8N1 serialiser
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] txCommand,
    output logic [31:0] txStatus,
    output logic        txd
);

    localparam int                BAUD_W    = $clog2(CLOCKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLOCKS_PER_BIT - 1);

    UartTxState_t             state_q, state_d;
    logic [BAUD_W-1:0]        baud_q, baud_d;
    logic [7:0]               shift_q, shift_d;
    logic [2:0]               bit_q, bit_d;
    logic                     txd_q, txd_d;
    logic                     ack_q, ack_d;
    logic                     push;
    logic                     pop;
    logic [7:0]               fifo_dout;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                     unused_cmd;

    assign unused_cmd = ^txCommand[31:9];

    // A differing toggle is a pending request; it waits while the FIFO is full
    assign push  = (txCommand[UART_CMD_TOGGLE] != ack_q) && !fifo_full;
    assign ack_d = push ? txCommand[UART_CMD_TOGGLE] : ack_q;

    uart_tx_fifo #(
        .DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (txCommand[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state logic: each state lasts until the baud counter reads zero
    always_comb begin
        state_d = state_q;
        baud_d  = (baud_q == '0) ? baud_q : baud_q - 1'b1;
        shift_d = shift_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = BAUD_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    pop     = !fifo_empty;
                    shift_d = fifo_empty ? shift_q : fifo_dout;
                    baud_d  = BAUD_LOAD;
                    state_d = fifo_empty ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
        txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    // State registers; reset abandons any frame and forces the line high at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
        end
    end

    assign txd = txd_q;

    // Status word assembly
    always_comb begin
        txStatus                                  = '0;
        txStatus[UART_STATUS_ACK]                 = ack_q;
        txStatus[UART_STATUS_FULL]                = fifo_full;
        txStatus[UART_STATUS_EMPTY]               = fifo_empty;
        txStatus[UART_STATUS_BUSY]                = state_q != IDLE;
        txStatus[UART_STATUS_COUNT_LSB +: 4]      = 4'(fifo_count);
    end

endmodule
